csr_to_banked_ram_bridge: RTL and testbench

// - Bridges a PeakRDL external-block CSR access port to NUM_BANKS single-port RAM banks.
// - Next generation of the CSR-to-RAM bridge: banked address decode, configurable RAM read latency
//   (RD_LATENCY), and bit-granular writes via an internal read-modify-write (RMW) sequence.
// - Sits between the generated CSR block and the RAM macros; one access in flight at a time.

---
 rtl/csr_to_ram_bridge_pkg.sv | 33 +++
 rtl/csr_to_banked_ram_bridge_rd_mux.sv | 22 ++
 rtl/csr_to_banked_ram_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_csr_to_banked_ram_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_to_ram_bridge_pkg.sv
// Shared types and helpers for the CSR-to-banked-RAM bridge.
// Byte classification is sized for the widest supported word.
package csr_to_ram_bridge_pkg;

  localparam int RD_LATENCY_MAX = 4;
  localparam int MAX_BPW = 64;
  localparam int CNT_W = $clog2(RD_LATENCY_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW_RD_WAIT,
    RMW_WR
  } state_t;

  typedef struct packed {
    logic [MAX_BPW-1:0] full;
    logic [MAX_BPW-1:0] partial;
  } byte_class_t;

  function automatic byte_class_t byte_class(
    input logic [MAX_BPW*8-1:0] bit_en
  );
    byte_class_t c;
    c = '0;
    for (int k = 0; k < MAX_BPW; k++) begin
      c.full[k] = &bit_en[8*k +: 8];
      c.partial[k] = (|bit_en[8*k +: 8]) && !c.full[k];
    end
    return c;
  endfunction

endpackage

// File: rtl/csr_to_banked_ram_bridge_rd_mux.sv
// Bank read-data select for the CSR-to-banked-RAM bridge.
// The bank index comes from the registered request.
module csr_bank_rd_mux #(
  parameter int W = 32,
  parameter int N = 4,
  parameter int SW = 2
) (
  input  logic [SW-1:0]  bank_sel,
  input  logic [N*W-1:0] rd_data,
  output logic [W-1:0]   word
);

  always_comb begin
    word = '0;
    for (int b = 0; b < N; b++) begin
      if (bank_sel == SW'(b)) begin
        word = rd_data[b*W +: W];
      end
    end
  end

endmodule

// File: rtl/csr_to_banked_ram_bridge.sv
// PeakRDL external-block port to banked single-port RAMs.
// Partial-byte writes are done as an internal read-modify-write.
module csr_to_banked_ram_bridge
  import csr_to_ram_bridge_pkg::*;
#(
  parameter int WORD_BIT_WIDTH = 32,
  parameter int BYTE_ADDR_BIT_WIDTH = 10,
  parameter int NUM_BANKS = 4,
  parameter int RD_LATENCY = 1,
  localparam int BPW = WORD_BIT_WIDTH / 8,
  localparam int BANK_SEL_W = $clog2(NUM_BANKS),
  localparam int WORD_ADDR_W =
    BYTE_ADDR_BIT_WIDTH - $clog2(BPW) - BANK_SEL_W
) (
  input  logic                          i_clk,
  input  logic                          i_arst_n,
  input  logic                          i_acc_req,
  input  logic                          i_acc_req_is_wr,
  input  logic [BYTE_ADDR_BIT_WIDTH-1:0] i_byte_addr,
  input  logic [WORD_BIT_WIDTH-1:0]     i_wr_data,
  input  logic [WORD_BIT_WIDTH-1:0]     i_wr_bit_en,
  output logic                          o_rd_ack,
  output logic [WORD_BIT_WIDTH-1:0]     o_rd_data,
  output logic                          o_wr_ack,
  output logic                          o_busy,
  output logic                          o_err_overlap,
  output logic [NUM_BANKS-1:0]          o_ram_en,
  output logic [NUM_BANKS-1:0]          o_ram_we,
  output logic [WORD_ADDR_W-1:0]        o_ram_word_addr,
  output logic [BPW-1:0]                o_ram_wr_byte_en,
  output logic [WORD_BIT_WIDTH-1:0]     o_ram_wr_data,
  input  logic [NUM_BANKS*WORD_BIT_WIDTH-1:0] i_ram_rd_data
);

  localparam int OFS_W = $clog2(BPW);
  localparam int WI_W = BYTE_ADDR_BIT_WIDTH - OFS_W;
  localparam int BSW = (BANK_SEL_W > 0) ? BANK_SEL_W : 1;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LATENCY);

  if (WORD_BIT_WIDTH < 8 ||
      (WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0 ||
      WORD_BIT_WIDTH > 8 * MAX_BPW) begin : g_bad_word
    $error("WORD_BIT_WIDTH must be a power of 2 in 8..512");
  end
  if (NUM_BANKS < 1 ||
      (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
    $error("NUM_BANKS must be a power of 2, >= 1");
  end
  if (RD_LATENCY < 1 ||
      RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_lat
    $error("RD_LATENCY must be 1..4");
  end
  if (WORD_ADDR_W < 1) begin : g_bad_addr
    $error("WORD_ADDR_W must be >= 1");
  end

  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [BSW-1:0] bank_q;
  logic [WORD_ADDR_W-1:0] addr_q;
  logic [WORD_BIT_WIDTH-1:0] wdata_q;
  logic [WORD_BIT_WIDTH-1:0] bit_en_q;
  logic [BPW-1:0] be_q;
  logic wr_ack_q;
  logic err_q;

  logic [WI_W-1:0] word_idx;
  logic [BSW-1:0] req_bank;
  logic [WORD_ADDR_W-1:0] req_addr;

  assign word_idx = i_byte_addr[BYTE_ADDR_BIT_WIDTH-1:OFS_W];
  assign req_addr = word_idx[WORD_ADDR_W-1:0];

  if (NUM_BANKS > 1) begin : g_bank
    assign req_bank = word_idx[WI_W-1 -: BANK_SEL_W];
  end else begin : g_one_bank
    assign req_bank = '0;
  end

  if (OFS_W > 0) begin : g_lo
    logic unused_lo;
    assign unused_lo = ^i_byte_addr[OFS_W-1:0];
  end

  logic [MAX_BPW*8-1:0] be_ext;
  byte_class_t cls;
  logic [BPW-1:0] full_b;
  logic [BPW-1:0] part_b;

  always_comb begin
    be_ext = '0;
    be_ext[WORD_BIT_WIDTH-1:0] = i_wr_bit_en;
  end

  assign cls = byte_class(be_ext);
  assign full_b = cls.full[BPW-1:0];
  assign part_b = cls.partial[BPW-1:0];

  if (BPW < MAX_BPW) begin : g_cls_hi
    logic unused_cls;
    assign unused_cls = ^{cls.full[MAX_BPW-1:BPW],
                          cls.partial[MAX_BPW-1:BPW]};
  end

  logic acc;
  logic has_part;
  logic rd_strobe;
  logic wr_strobe;
  logic rmw_go;
  logic rd_done;
  logic [WORD_BIT_WIDTH-1:0] mux_word;
  logic [WORD_BIT_WIDTH-1:0] merged;

  assign acc = i_acc_req && (state == IDLE);
  assign has_part = |part_b;
  assign rd_strobe = acc && (!i_acc_req_is_wr || has_part);
  assign wr_strobe = acc && i_acc_req_is_wr &&
                     !has_part && (|full_b);
  assign rmw_go = (state == RMW_RD_WAIT) && (cnt == LAT);
  assign rd_done = (state == RD_WAIT) && (cnt == LAT);

  csr_bank_rd_mux #(
    .W (WORD_BIT_WIDTH),
    .N (NUM_BANKS),
    .SW(BSW)
  ) u_rd_mux (
    .bank_sel(bank_q),
    .rd_data (i_ram_rd_data),
    .word    (mux_word)
  );

  // Merge uses the live RAM word, valid exactly in the rmw_go cycle.
  assign merged = (mux_word & ~bit_en_q) | (wdata_q & bit_en_q);

  always_comb begin
    o_ram_en = '0;
    o_ram_we = '0;
    o_ram_word_addr = '0;
    o_ram_wr_byte_en = '0;
    o_ram_wr_data = '0;
    unique case (1'b1)
      rd_strobe: begin
        o_ram_en = NUM_BANKS'(1) << req_bank;
        o_ram_word_addr = req_addr;
      end
      wr_strobe: begin
        o_ram_en = NUM_BANKS'(1) << req_bank;
        o_ram_we = NUM_BANKS'(1) << req_bank;
        o_ram_word_addr = req_addr;
        o_ram_wr_byte_en = full_b;
        o_ram_wr_data = i_wr_data;
      end
      rmw_go: begin
        o_ram_en = NUM_BANKS'(1) << bank_q;
        o_ram_we = NUM_BANKS'(1) << bank_q;
        o_ram_word_addr = addr_q;
        o_ram_wr_byte_en = be_q;
        o_ram_wr_data = merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
      cnt <= '0;
      bank_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      bit_en_q <= '0;
      be_q <= '0;
      wr_ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      if (i_acc_req && state != IDLE) begin
        err_q <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (i_acc_req) begin
            bank_q <= req_bank;
            addr_q <= req_addr;
            wdata_q <= i_wr_data;
            bit_en_q <= i_wr_bit_en;
            be_q <= full_b | part_b;
            if (!i_acc_req_is_wr) begin
              state <= RD_WAIT;
              cnt <= CNT_W'(1);
            end else if (has_part) begin
              state <= RMW_RD_WAIT;
              cnt <= CNT_W'(1);
            end else begin
              wr_ack_q <= 1'b1;
            end
          end
        end
        RD_WAIT, RMW_RD_WAIT: begin
          if (cnt == LAT) begin
            cnt <= '0;
            state <= (state == RD_WAIT) ? IDLE : RMW_WR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RMW_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_rd_ack = rd_done;
  assign o_rd_data = rd_done ? mux_word : '0;
  assign o_wr_ack = wr_ack_q || (state == RMW_WR);
  assign o_busy = (state != IDLE);
  assign o_err_overlap = err_q;

endmodule

// File: tb/tb_csr_to_banked_ram_bridge.sv
// Directed bench: three bridges with RD_LATENCY 1, 2, 3
// share stimulus; each scenario checks the relevant one.
module tb_csr_to_banked_ram_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req;
  logic is_wr;
  logic [9:0] addr;
  logic [31:0] wdata;
  logic [31:0] bit_en;
  logic [127:0] ram_rd;

  logic [3:1] rd_ack;
  logic [3:1] wr_ack;
  logic [3:1] busy;
  logic [3:1] err;
  logic [31:0] rd_data [1:3];
  logic [3:0] en [1:3];
  logic [3:0] we [1:3];
  logic [5:0] waddr [1:3];
  logic [3:0] be [1:3];
  logic [31:0] ram_wd [1:3];

  int vecs = 0;
  int errs = 0;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    csr_to_banked_ram_bridge #(
      .WORD_BIT_WIDTH(32),
      .BYTE_ADDR_BIT_WIDTH(10),
      .NUM_BANKS(4),
      .RD_LATENCY(g)
    ) u_dut (
      .i_clk(clk),
      .i_arst_n(rst_n),
      .i_acc_req(req),
      .i_acc_req_is_wr(is_wr),
      .i_byte_addr(addr),
      .i_wr_data(wdata),
      .i_wr_bit_en(bit_en),
      .o_rd_ack(rd_ack[g]),
      .o_rd_data(rd_data[g]),
      .o_wr_ack(wr_ack[g]),
      .o_busy(busy[g]),
      .o_err_overlap(err[g]),
      .o_ram_en(en[g]),
      .o_ram_we(we[g]),
      .o_ram_word_addr(waddr[g]),
      .o_ram_wr_byte_en(be[g]),
      .o_ram_wr_data(ram_wd[g]),
      .i_ram_rd_data(ram_rd)
    );
  end

  task automatic drive(input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [31:0] b);
    @(negedge clk);
    req = 1'b1;
    is_wr = w;
    addr = a;
    wdata = d;
    bit_en = b;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    req = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    int acks;
    logic [3:0] en_seen;
    rst_n = 1'b0;
    #1;
    for (int i = 1; i <= 3; i++) begin
      vecs++;
      if ({rd_ack[i], wr_ack[i], busy[i], err[i]} !== 4'b0 ||
          en[i] !== 4'b0 || we[i] !== 4'b0 ||
          rd_data[i] !== 32'h0 || waddr[i] !== 6'h0 ||
          be[i] !== 4'h0 || ram_wd[i] !== 32'h0) begin
        errs++;
        $display("FAIL reset_idle dut%0d: busy=%b err=%b en=%b", i,
                 busy[i], err[i], en[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 10'h3C4, 32'h0, 32'h0);
    step();
    vecs++;
    if (busy[3] !== 1'b1) begin
      errs++;
      $display("FAIL reset_busy_before: got %b want 1", busy[3]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (busy[3] !== 1'b0 || rd_ack[3] !== 1'b0 || en[3] !== 4'b0) begin
      errs++;
      $display("FAIL reset_abort: busy=%b ack=%b en=%b want 0",
               busy[3], rd_ack[3], en[3]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    en_seen = 4'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      acks += int'(rd_ack[3]);
      en_seen |= en[3];
    end
    vecs++;
    if (acks !== 0 || en_seen !== 4'b0) begin
      errs++;
      $display("FAIL reset_no_ack: acks=%0d en=%b want 0", acks, en_seen);
    end
  endtask

  task automatic test_read();
    ram_rd = {32'hDEADBEEF, 32'hCAFEF00D, 32'h11111111, 32'h22222222};
    // 0x2C4 -> word index 0xB1: bank 2, word 0x31
    drive(1'b0, 10'h2C4, 32'h0, 32'h0);
    vecs++;
    if (en[2] !== 4'b0100 || waddr[2] !== 6'h31 || we[2] !== 4'b0) begin
      errs++;
      $display("FAIL read_strobe: en=%b addr=%h want 0100 31", en[2], waddr[2]);
    end
    step();
    vecs++;
    if (rd_ack[2] !== 1'b0 || busy[2] !== 1'b1) begin
      errs++;
      $display("FAIL read_c1: ack=%b busy=%b want 0 1", rd_ack[2], busy[2]);
    end
    step();
    vecs++;
    if (rd_ack[2] !== 1'b1 || rd_data[2] !== 32'hCAFEF00D) begin
      errs++;
      $display("FAIL read_c2: ack=%b data=%h want 1 cafef00d",
               rd_ack[2], rd_data[2]);
    end
    step();
    vecs++;
    if (rd_ack[2] !== 1'b0 || rd_data[2] !== 32'h0 || busy[2] !== 1'b0) begin
      errs++;
      $display("FAIL read_c3: ack=%b data=%h busy=%b want 0",
               rd_ack[2], rd_data[2], busy[2]);
    end
    step();
    step();
    drive(1'b0, 10'h3C4, 32'h0, 32'h0);
    vecs++;
    if (en[2] !== 4'b1000 || waddr[2] !== 6'h31) begin
      errs++;
      $display("FAIL read3_strobe: en=%b addr=%h want 1000 31", en[2], waddr[2]);
    end
    step();
    step();
    vecs++;
    if (rd_ack[2] !== 1'b1 || rd_data[2] !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL read3_data: ack=%b data=%h want 1 deadbeef",
               rd_ack[2], rd_data[2]);
    end
    repeat (3) step();
  endtask

  task automatic test_full_write();
    drive(1'b1, 10'h008, 32'h12345678, 32'h0000FFFF);
    vecs++;
    if (en[1] !== 4'b0001 || we[1] !== 4'b0001 || be[1] !== 4'b0011 ||
        ram_wd[1] !== 32'h12345678 || waddr[1] !== 6'h02) begin
      errs++;
      $display("FAIL wr_strobe: en=%b we=%b be=%b d=%h a=%h",
               en[1], we[1], be[1], ram_wd[1], waddr[1]);
    end
    vecs++;
    if (wr_ack[1] !== 1'b0) begin
      errs++;
      $display("FAIL wr_c0_ack: got %b want 0", wr_ack[1]);
    end
    step();
    vecs++;
    if (wr_ack[1] !== 1'b1 || en[1] !== 4'b0 || busy[1] !== 1'b0) begin
      errs++;
      $display("FAIL wr_c1: ack=%b en=%b busy=%b want 1 0 0",
               wr_ack[1], en[1], busy[1]);
    end
    step();
    vecs++;
    if (wr_ack[1] !== 1'b0) begin
      errs++;
      $display("FAIL wr_c2_ack: got %b want 0", wr_ack[1]);
    end
    repeat (3) step();
  endtask

  task automatic test_rmw();
    ram_rd = {32'h0, 32'h0, 32'h0, 32'hAABBCCDD};
    drive(1'b1, 10'h000, 32'h00000050, 32'h000000F0);
    vecs++;
    if (en[1] !== 4'b0001 || we[1] !== 4'b0000 || busy[1] !== 1'b0) begin
      errs++;
      $display("FAIL rmw_c0: en=%b we=%b busy=%b want 0001 0000 0",
               en[1], we[1], busy[1]);
    end
    step();
    vecs++;
    if (en[1] !== 4'b0001 || we[1] !== 4'b0001 ||
        ram_wd[1] !== 32'hAABBCC5D || be[1] !== 4'b0001 ||
        wr_ack[1] !== 1'b0) begin
      errs++;
      $display("FAIL rmw_c1: we=%b d=%h be=%b ack=%b want 0001 aabbcc5d 0001 0",
               we[1], ram_wd[1], be[1], wr_ack[1]);
    end
    step();
    vecs++;
    if (wr_ack[1] !== 1'b1 || we[1] !== 4'b0 || rd_ack[1] !== 1'b0) begin
      errs++;
      $display("FAIL rmw_c2: ack=%b we=%b rd_ack=%b want 1 0 0",
               wr_ack[1], we[1], rd_ack[1]);
    end
    step();
    vecs++;
    if (wr_ack[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errs++;
      $display("FAIL rmw_c3: ack=%b busy=%b want 0 0", wr_ack[1], busy[1]);
    end
    repeat (3) step();
  endtask

  task automatic test_overlap();
    int acks;
    int ack_cyc;
    do_reset();
    ram_rd = {32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    drive(1'b0, 10'h3C4, 32'h0, 32'h0);
    drive(1'b0, 10'h004, 32'h0, 32'h0);
    vecs++;
    if (busy[3] !== 1'b1 || err[3] !== 1'b0) begin
      errs++;
      $display("FAIL ovl_c1: busy=%b err=%b want 1 0", busy[3], err[3]);
    end
    acks = 0;
    ack_cyc = -1;
    for (int c = 2; c < 9; c++) begin
      step();
      if (rd_ack[3] === 1'b1) begin
        acks++;
        ack_cyc = c;
      end
    end
    vecs++;
    if (acks !== 1 || ack_cyc !== 3) begin
      errs++;
      $display("FAIL ovl_acks: count=%0d cycle=%0d want 1 3", acks, ack_cyc);
    end
    vecs++;
    if (err[3] !== 1'b1) begin
      errs++;
      $display("FAIL ovl_err: got %b want 1", err[3]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ram_rd = {32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    drive(1'b1, 10'h008, 32'hA5A5A5A5, 32'hFFFFFFFF);
    vecs++;
    if (we[1] !== 4'b0001 || be[1] !== 4'b1111) begin
      errs++;
      $display("FAIL b2b_wr: we=%b be=%b want 0001 1111", we[1], be[1]);
    end
    step();
    vecs++;
    if (wr_ack[1] !== 1'b1) begin
      errs++;
      $display("FAIL b2b_wr_ack: got %b want 1", wr_ack[1]);
    end
    drive(1'b0, 10'h3C4, 32'h0, 32'h0);
    vecs++;
    if (en[1] !== 4'b1000 || wr_ack[1] !== 1'b0) begin
      errs++;
      $display("FAIL b2b_rd_strobe: en=%b ack=%b want 1000 0", en[1], wr_ack[1]);
    end
    step();
    vecs++;
    if (rd_ack[1] !== 1'b1 || rd_data[1] !== 32'hDEADBEEF ||
        wr_ack[1] !== 1'b0) begin
      errs++;
      $display("FAIL b2b_rd_ack: ack=%b data=%h wr_ack=%b want 1 deadbeef 0",
               rd_ack[1], rd_data[1], wr_ack[1]);
    end
    drive(1'b1, 10'h010, 32'hFFFFFFFF, 32'h0);
    vecs++;
    if (en[1] !== 4'b0 || we[1] !== 4'b0) begin
      errs++;
      $display("FAIL zero_be_strobe: en=%b we=%b want 0", en[1], we[1]);
    end
    step();
    vecs++;
    if (wr_ack[1] !== 1'b1 || busy[1] !== 1'b0) begin
      errs++;
      $display("FAIL zero_be_ack: ack=%b busy=%b want 1 0", wr_ack[1], busy[1]);
    end
    step();
    vecs++;
    if (err[1] !== 1'b0 || wr_ack[1] !== 1'b0) begin
      errs++;
      $display("FAIL b2b_err: err=%b ack=%b want 0 0", err[1], wr_ack[1]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req = 1'b0;
    is_wr = 1'b0;
    addr = '0;
    wdata = '0;
    bit_en = '0;
    ram_rd = '0;
    test_reset();
    test_read();
    test_full_write();
    test_rmw();
    test_overlap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
